// File: rtl/router_pkg.sv
// Shared types and constants for the router input stage.
package router_pkg;

  localparam int PKT_W   = 34;
  localparam int DEST_W  = 2;
  localparam int NUM_SRC = 3;

  // Destination core id occupies the top DEST_W bits of a packet.
  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [1:0] {
    SRC_EAST  = 2'd0,
    SRC_WEST  = 2'd1,
    SRC_LOCAL = 2'd2
  } src_e;

  // Round-robin successor: EAST -> WEST -> LOCAL -> EAST.
  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_EAST: return SRC_WEST;
      SRC_WEST: return SRC_LOCAL;
      default:  return SRC_EAST;
    endcase
  endfunction

endpackage

// File: rtl/router_in_fifo.sv
// Small registered FIFO buffering one packet source in front of the arbiter.
module router_in_fifo
  import router_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = pkt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  T                 mem_q [DEPTH];

  logic push_en;
  logic pop_en;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if a caller ignores full/empty.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the occupancy count alone decides which entries are valid.
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/router_input_arbiter.sv
// Three-source input stage: per-source FIFOs, round-robin grant, registered output slot.
module router_input_arbiter
  import router_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       east_valid,
  input  pkt_t       east_pkt,
  output logic       east_ready,
  input  logic       west_valid,
  input  pkt_t       west_pkt,
  output logic       west_ready,
  input  logic       local_valid,
  input  pkt_t       local_pkt,
  output logic       local_ready,
  output logic       out_valid,
  output pkt_t       out_pkt,
  output logic [1:0] out_src,
  input  logic       out_ready,
  output logic       busy
);

  logic [NUM_SRC-1:0] in_valid;
  logic [NUM_SRC-1:0] in_ready;
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] pop;
  pkt_t               in_pkt   [NUM_SRC];
  pkt_t               fifo_head[NUM_SRC];

  src_e last_grant_q, last_grant_d;
  logic out_valid_q,  out_valid_d;
  pkt_t out_pkt_q,    out_pkt_d;
  src_e out_src_q,    out_src_d;

  src_e grant;
  logic grant_found;
  src_e cand;
  logic slot_free;

  assign in_valid = {local_valid, west_valid, east_valid};
  assign in_pkt[SRC_EAST]  = east_pkt;
  assign in_pkt[SRC_WEST]  = west_pkt;
  assign in_pkt[SRC_LOCAL] = local_pkt;

  // Ready depends only on registered FIFO state and reset, never on valid.
  assign in_ready    = ~fifo_full & {NUM_SRC{~rst}};
  assign east_ready  = in_ready[SRC_EAST];
  assign west_ready  = in_ready[SRC_WEST];
  assign local_ready = in_ready[SRC_LOCAL];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    router_in_fifo #(
      .DEPTH (DEPTH),
      .T     (pkt_t)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (in_valid[g] && in_ready[g]),
      .push_data_i (in_pkt[g]),
      .pop_i       (pop[g]),
      .full_o      (fifo_full[g]),
      .empty_o     (fifo_empty[g]),
      .head_o      (fifo_head[g])
    );
  end

  // Round-robin search starting after the last granted source.
  always_comb begin
    grant       = SRC_EAST;
    grant_found = 1'b0;
    cand        = next_src(last_grant_q);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_found && !fifo_empty[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
      cand = next_src(cand);
    end
  end

  assign slot_free = !out_valid_q || out_ready;

  // Output slot next state: load the winner when the slot is free, else hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pkt_d    = out_pkt_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    pop          = '0;
    if (slot_free) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_pkt_d    = fifo_head[grant];
        out_src_d    = grant;
        last_grant_d = grant;
        pop[grant]   = 1'b1;
      end
    end
  end

  // Output slot and arbitration history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_pkt_q    <= '0;
      out_src_q    <= SRC_EAST;
      last_grant_q <= SRC_LOCAL;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pkt_q    <= out_pkt_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign out_src   = out_src_q;
  assign busy      = !(&fifo_empty) || out_valid_q;

endmodule
